// File: rtl/vrased_rst_seq.sv
// Turns any VRASED monitor violation into a fixed-length registered PUC request,
// then waits for the core to fetch from the reset handler before re-arming.
module vrased_rst_seq #(
  parameter int unsigned   HOLD_CYCLES   = 16,
  parameter int unsigned   CNT_W         = 8,
  parameter logic [15:0]   RESET_HANDLER = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       viol,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             puc_req,
  output logic             busy,
  output logic [5:0]       cause,
  output logic [15:0]      last_pc,
  output logic [CNT_W-1:0] viol_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $error("vrased_rst_seq: HOLD_CYCLES must be in 1..65535");
  end

  state_t           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [5:0]       cause_d;
  logic [15:0]      last_pc_d, last_pc_base;
  logic [CNT_W-1:0] cnt_d, cnt_base, cnt_inc;
  logic             evt;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    hold_d       = hold_q;
    // The clear is applied before this cycle's violations are merged in.
    cause_d      = (cause_clr ? 6'd0 : cause) | viol;
    last_pc_base = cause_clr ? 16'd0 : last_pc;
    cnt_base     = cause_clr ? '0 : viol_cnt;
    cnt_inc      = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    last_pc_d    = last_pc_base;
    cnt_d        = cnt_base;
    evt          = (|viol) && (state_q != HOLD);

    unique case (state_q)
      IDLE: begin
        if (evt) begin
          state_d   = HOLD;
          hold_d    = HOLD_LOAD;
          last_pc_d = pc;
          cnt_d     = cnt_inc;
        end
      end
      HOLD: begin
        if (hold_q == 16'd0) state_d = WAIT_PC;
        else                 hold_d  = hold_q - 16'd1;
      end
      WAIT_PC: begin
        // A fresh violation wins over the core reaching the reset handler.
        if (evt) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          if (cnt_base == '0) last_pc_d = pc;
          cnt_d   = cnt_inc;
        end else if (pc == RESET_HANDLER) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hold_q   <= 16'd0;
      puc_req  <= 1'b0;
      busy     <= 1'b0;
      cause    <= 6'd0;
      last_pc  <= 16'd0;
      viol_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q  <= state_d;
      hold_q   <= hold_d;
      puc_req  <= (state_d == HOLD);
      busy     <= (state_d != IDLE);
      cause    <= cause_d;
      last_pc  <= last_pc_d;
      viol_cnt <= cnt_d;
    end
  end

endmodule
